// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1101 serial pattern detector.
// Imported by the RTL and by benches/assertions that need the reference pattern.
package seq_det_pkg;

    localparam logic [3:0] PATTERN = 4'b1101;

    // Each state records how much of PATTERN the most recent bits already match.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_11   = 3'd2,
        S_110  = 3'd3,
        S_HIT  = 3'd4
    } state_e;

endpackage : seq_det_pkg

// File: rtl/seq_det_cnt.sv
// Saturating up-counter: adds one per inc pulse, holds at all-ones, cleared only by rst_n.
// Used by seq_det as its hit counter when SEQ_DET_COUNT_EN is defined.
module seq_det_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : seq_det_cnt

// File: rtl/seq_det.sv
// Moore detector raising w for one cycle after each (overlapping) 1101 on B.
// Define SEQ_DET_COUNT_EN to add the saturating hit_cnt output.
module seq_det
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             B,
    output logic             w
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_det: CNT_W must be at least 1");
    end

    state_e state_q;
    state_e state_d;
    logic   w_q;
    logic   w_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = B ? S_1   : S_IDLE;
            S_1:     state_d = B ? S_11  : S_IDLE;
            S_11:    state_d = B ? S_11  : S_110;
            S_110:   state_d = B ? S_HIT : S_IDLE;
            S_HIT:   state_d = B ? S_11  : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // w is taken from a flop fed by the next-state decode, so it changes only on Clk.
        w_d = (state_d == S_HIT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
        end
    end

    assign w = w_q;

`ifdef SEQ_DET_COUNT_EN
    // S_HIT never loops onto itself, so w_d marks exactly the edges that enter it.
    seq_det_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (Clk),
        .rst_n (Rst),
        .inc   (w_d),
        .cnt   (hit_cnt)
    );
`endif

endmodule : seq_det

// File: tb/tb_seq_det.sv
// Self-checking bench for seq_det: directed scenarios plus random bits against a sliding-window model.
// Checks hit_cnt as well when compiled with SEQ_DET_COUNT_EN.
module tb_seq_det;
    import seq_det_pkg::*;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic Clk;
    logic Rst;
    logic B;
    logic w;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    seq_det #(
        .CNT_W (CNT_W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .B       (B),
        .w       (w)
`ifdef SEQ_DET_COUNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: the last four bits seen since reset, and the total number of matches.
    logic [3:0] hist;
    int         hits;
    int         cycle;
    int         pulse_cycles[$];

    int n_vec;
    int n_err;

    task automatic check_outputs(input logic exp_w, input string tag);
        n_vec++;
        if (w !== exp_w) begin
            n_err++;
            $display("FAIL %s: w=%b expected %b (cycle %0d)", tag, w, exp_w, cycle);
        end
`ifdef SEQ_DET_COUNT_EN
        begin
            logic [CNT_W-1:0] exp_cnt;
            exp_cnt = (hits > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(hits);
            n_vec++;
            if (hit_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL %s hit_cnt: got %0d expected %0d (cycle %0d)", tag, hit_cnt, exp_cnt, cycle);
            end
        end
`endif
    endtask

    // Drive one bit, let the DUT sample it, then compare 1 time unit after the edge.
    task automatic step(input logic b, input string tag);
        logic exp_w;
        @(negedge Clk);
        B = b;
        @(posedge Clk);
        cycle++;
        hist  = {hist[2:0], b};
        exp_w = (hist == PATTERN);
        if (exp_w) hits++;
        #1;
        if (w === 1'b1) pulse_cycles.push_back(cycle);
        check_outputs(exp_w, tag);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b0;
        hist = 4'b0000;
        hits = 0;
        #1;
        check_outputs(1'b0, "reset_async");
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst  = 1'b0;
        B    = 1'b0;
        hist = 4'b0000;
        hits = 0;
        #1;
        check_outputs(1'b0, "reset_initial");
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            B = ~B;
            @(posedge Clk);
            #1;
            check_outputs(1'b0, "reset_held");
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_single_match();
        logic [3:0] seq;
        seq = 4'b1101;
        apply_reset();
        for (int i = 3; i >= 0; i--) step(seq[i], "single_match");
        step(1'b0, "single_match_fall");
    endtask

    task automatic test_back_to_back();
        logic [6:0] seq;
        seq = 7'b1101101;
        apply_reset();
        pulse_cycles.delete();
        for (int i = 6; i >= 0; i--) step(seq[i], "back_to_back");
        step(1'b0, "back_to_back_tail");
        n_vec++;
        if (pulse_cycles.size() != 2) begin
            n_err++;
            $display("FAIL back_to_back_count: got %0d pulses expected 2", pulse_cycles.size());
        end else begin
            n_vec++;
            if (pulse_cycles[1] - pulse_cycles[0] != 3) begin
                n_err++;
                $display("FAIL back_to_back_gap: got %0d cycles expected 3",
                         pulse_cycles[1] - pulse_cycles[0]);
            end
        end
    endtask

    task automatic test_near_miss();
        logic [6:0] seq;
        seq = 7'b1100101;
        apply_reset();
        pulse_cycles.delete();
        for (int i = 6; i >= 0; i--) step(seq[i], "near_miss");
        n_vec++;
        if (pulse_cycles.size() != 0) begin
            n_err++;
            $display("FAIL near_miss_count: got %0d pulses expected 0", pulse_cycles.size());
        end
    endtask

    task automatic test_reset_mid_sequence();
        apply_reset();
        step(1'b1, "mid_reset_pre");
        step(1'b1, "mid_reset_pre");
        step(1'b0, "mid_reset_pre");
        // Short reset pulse between edges: discards the partial 110.
        @(negedge Clk);
        Rst = 1'b0;
        hist = 4'b0000;
        hits = 0;
        #2;
        Rst = 1'b1;
        step(1'b1, "mid_reset_no_hit");
        step(1'b1, "mid_reset_restart");
        step(1'b0, "mid_reset_restart");
        step(1'b1, "mid_reset_restart_hit");
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_saturation();
        logic [3:0] seq;
        seq = PATTERN;
        apply_reset();
        for (int blk = 0; blk < 300; blk++) begin
            for (int i = 3; i >= 0; i--) step(seq[i], "saturation");
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cycle = 0;
        test_reset();
        test_single_match();
        test_back_to_back();
        test_near_miss();
        test_reset_mid_sequence();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_det
